// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction fetch sequencer:
//   fetch_state_e  fetch FSM state (IDLE, RUN, STOP)
//   fetch_entry_t  one prefetched instruction {pc, instr}
//   NOP_INSTR      instruction reported when nothing is valid
//   PC_STEP        byte distance between consecutive instructions
//   align_pc()     clears the two low address bits of a redirect target
// -----------------------------------------------------------------------------
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Small synchronous FIFO holding prefetched instructions.
//   clk, rst_n  clock, asynchronous active-low reset
//   push        write wr_data (taken when not full, or when a pop frees a slot)
//   pop         drop the head entry (ignored when empty)
//   flush       discard all content; overrides push and pop
//   wr_data     entry to write
//   full        count == DEPTH
//   empty       count == 0
//   head        oldest entry (meaningful only when !empty)
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = fetch_entry_t
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  logic   pop,
  input  logic   flush,
  input  entry_t wr_data,
  output logic   full,
  output logic   empty,
  output entry_t head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is not reset; the count alone decides which
  // entries are live, so clearing the data would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// inst_fetch_ctrl
// Fetch sequencer: owns the PC, reads the combinational program ROM once per
// cycle into a prefetch FIFO and hands {pc, instr} to decode.
//   clk, rst_n      clock, asynchronous active-low reset
//   start, stop     single-cycle pulses; stop wins when both are high
//   redirect_valid  execute requests a PC change (flushes the FIFO)
//   redirect_pc     redirect target, aligned down to a word
//   rom_addr        ROM address, always the current pc
//   rom_data        ROM read data for rom_addr, same cycle
//   out_valid       FIFO head valid
//   out_ready       decode accepts the head
//   out_pc          head pc (0 when !out_valid)
//   out_instr       head instruction (NOP_INSTR when !out_valid)
//   misalign_err    one-cycle pulse after a redirect with redirect_pc[1:0]!=0
//   running         FSM is in RUN
// -----------------------------------------------------------------------------
module inst_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INSTR  = fetch_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        misalign_err,
  output logic        running
);

  import fetch_pkg::*;

  fetch_state_e  state;
  fetch_state_e  state_nxt;
  logic [31:0]   pc;
  fetch_entry_t  wr_entry;
  fetch_entry_t  head;
  logic          full;
  logic          empty;
  logic          pop;
  logic          push;

  // A redirect flushes the FIFO, so a handshake in the same cycle must not
  // count as consumed and nothing fetched from the stale pc may be kept.
  assign pop      = out_valid && out_ready && !redirect_valid;
  assign push     = (state == RUN) && !redirect_valid && (!full || pop);
  assign wr_entry = '{pc: pc, instr: rom_data};

  fetch_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (fetch_entry_t)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .flush   (redirect_valid),
    .wr_data (wr_entry),
    .full    (full),
    .empty   (empty),
    .head    (head)
  );

  // NOTE: next-state is defaulted to the current state before the case, so
  // every path assigns it and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start && !stop) state_nxt = RUN;
      RUN:     if (stop)           state_nxt = STOP;
      STOP:    if (start && !stop) state_nxt = RUN;
      default:                     state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      misalign_err <= 1'b0;
    end else begin
      state        <= state_nxt;
      misalign_err <= redirect_valid && (redirect_pc[1:0] != 2'b00);
      if (redirect_valid) pc <= align_pc(redirect_pc);
      else if (push)      pc <= pc + PC_STEP;
    end
  end

  assign rom_addr  = pc;
  assign running   = (state == RUN);
  assign out_valid = !empty;
  assign out_pc    = empty ? 32'h0000_0000 : head.pc;
  assign out_instr = empty ? NOP_INSTR     : head.instr;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_ctrl
// Directed scenarios with literal expectations, then randomized start/stop/
// redirect/backpressure traffic. A queue-based model tracks what decode must
// see and is compared against the DUT on every falling edge.
// -----------------------------------------------------------------------------
module tb_inst_fetch_ctrl;

  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        misalign_err;
  logic        running;

  int n_cmp = 0;
  int n_err = 0;

  inst_fetch_ctrl #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (DEPTH),
    .NOP_INSTR  (NOP)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .stop           (stop),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .misalign_err   (misalign_err),
    .running        (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program ROM contents: a few fixed words, a pattern in low memory,
  // NOP everywhere else.
  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0050_0113;
      32'h0000_0004: return 32'h0FBD_01B7;
      32'h0000_0008: return 32'h0631_8193;
      32'h0000_0034: return 32'h0001_0183;
      default:       return (a < 32'h400) ? {a[15:0] ^ 16'h5A5A, a[15:0]} : NOP;
    endcase
  endfunction

  assign rom_data = rom(rom_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } m_ent_t;

  m_ent_t      m_q[$];
  logic [31:0] m_pc  = 32'h0;
  bit          m_run = 1'b0;
  bit          m_err = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_pc  = 32'h0;
      m_run = 1'b0;
      m_err = 1'b0;
    end else begin
      bit taken;
      bit fetch;
      taken = (m_q.size() > 0) && out_ready;
      m_err = redirect_valid && (redirect_pc % 4 != 0);
      if (redirect_valid) begin
        m_q.delete();
        m_pc = redirect_pc - (redirect_pc % 4);
      end else begin
        fetch = m_run && (m_q.size() < DEPTH || taken);
        if (taken) void'(m_q.pop_front());
        if (fetch) begin
          m_q.push_back('{pc: m_pc, instr: rom(m_pc)});
          m_pc = m_pc + 4;
        end
      end
      if (stop)       m_run = 1'b0;
      else if (start) m_run = 1'b1;
    end
  end

  // ---------------- per-cycle comparison ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      check("m_rom_addr",  rom_addr,      m_pc);
      check("m_running",   32'(running),  32'(m_run));
      check("m_misalign",  32'(misalign_err), 32'(m_err));
      check("m_out_valid", 32'(out_valid), 32'(m_q.size() > 0));
      if (m_q.size() > 0) begin
        check("m_out_pc",    out_pc,    m_q[0].pc);
        check("m_out_instr", out_instr, m_q[0].instr);
      end else begin
        check("m_out_pc_idle",    out_pc,    32'h0);
        check("m_out_instr_idle", out_instr, NOP);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    next();
    rst_n          = 1'b0;
    start          = 1'b0;
    stop           = 1'b0;
    redirect_valid = 1'b0;
    next();
    next();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n          = 1'b0;
    start          = 1'b0;
    stop           = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b1;
    next();
    next();
    rst_n = 1'b1;

    // Reset state, then straight-line fetch with decode always ready.
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_pc",    out_pc,         32'h0);
    check("rst_out_instr", out_instr,      NOP);
    check("rst_rom_addr",  rom_addr,       32'h0);
    check("rst_running",   32'(running),   32'h0);
    next(); start = 1'b1;
    next(); start = 1'b0;
    @(negedge clk);
    check("run_running",   32'(running),   32'h1);
    check("run_not_valid", 32'(out_valid), 32'h0);
    next(); @(negedge clk);
    check("seq0_pc", out_pc, 32'h00); check("seq0_instr", out_instr, 32'h0050_0113);
    next(); @(negedge clk);
    check("seq1_pc", out_pc, 32'h04); check("seq1_instr", out_instr, 32'h0FBD_01B7);
    next(); @(negedge clk);
    check("seq2_pc", out_pc, 32'h08); check("seq2_instr", out_instr, 32'h0631_8193);

    // Backpressure: FIFO fills with 0x00/0x04 and pc stalls at 0x08.
    do_reset();
    out_ready = 1'b0;
    next(); start = 1'b1;
    next(); start = 1'b0;
    next(); next(); next();
    @(negedge clk);
    check("bp_hold_pc",  out_pc,   32'h00);
    check("bp_rom_addr", rom_addr, 32'h08);
    next(); out_ready = 1'b1;
    @(negedge clk); check("bp_rel0", out_pc, 32'h00);
    next(); @(negedge clk); check("bp_rel1", out_pc, 32'h04);
    next(); @(negedge clk); check("bp_rel2", out_pc, 32'h08);

    // Redirect to 0x34 on a full FIFO with a simultaneous pop.
    next(); out_ready = 1'b0;
    next(); next(); next();
    next(); redirect_valid = 1'b1; redirect_pc = 32'h34; out_ready = 1'b1;
    @(negedge clk); check("rd_head_shown", 32'(out_valid), 32'h1);
    next(); redirect_valid = 1'b0;
    @(negedge clk);
    check("rd_flushed",  32'(out_valid), 32'h0);
    check("rd_rom_addr", rom_addr,       32'h34);
    next(); @(negedge clk);
    check("rd_pc",    out_pc,    32'h34);
    check("rd_instr", out_instr, 32'h0001_0183);
    next(); @(negedge clk); check("rd_pc_next", out_pc, 32'h38);

    // Misaligned redirect.
    next(); redirect_valid = 1'b1; redirect_pc = 32'h36;
    next(); redirect_valid = 1'b0;
    @(negedge clk);
    check("mis_pulse", 32'(misalign_err), 32'h1);
    check("mis_empty", 32'(out_valid),    32'h0);
    next(); @(negedge clk);
    check("mis_clear", 32'(misalign_err), 32'h0);
    check("mis_pc",    out_pc,            32'h34);

    // PC wrap, then stop and drain.
    next(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    next(); redirect_valid = 1'b0;
    next();
    stop = 1'b1;
    @(negedge clk);
    check("wrap_pc",       out_pc,    32'hFFFF_FFFC);
    check("wrap_instr",    out_instr, NOP);
    check("wrap_rom_addr", rom_addr,  32'h0);
    next(); stop = 1'b0;
    @(negedge clk);
    check("stop_running", 32'(running), 32'h0);
    check("stop_drain",   out_pc,       32'h0);
    next(); @(negedge clk);
    check("stop_empty",    32'(out_valid), 32'h0);
    check("stop_rom_addr", rom_addr,       32'h4);

    // Reset in the middle of a full FIFO.
    next(); out_ready = 1'b0; start = 1'b1;
    next(); start = 1'b0;
    next(); next(); next();
    @(negedge clk); check("mid_full_valid", 32'(out_valid), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid",   32'(out_valid), 32'h0);
    check("mid_rst_running", 32'(running),   32'h0);
    next(); next(); rst_n = 1'b1;
    next(); next();
    @(negedge clk);
    check("mid_idle_valid", 32'(out_valid), 32'h0);
    check("mid_idle_addr",  rom_addr,       32'h0);
    out_ready = 1'b1;
    next(); start = 1'b1;
    next(); start = 1'b0;
    next(); @(negedge clk);
    check("mid_restart_pc", out_pc, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      next();
      rst_n          = ($urandom_range(0, 999) != 0);
      start          = ($urandom_range(0, 99) < 10);
      stop           = ($urandom_range(0, 99) < 3);
      out_ready      = ($urandom_range(0, 99) < 70);
      redirect_valid = ($urandom_range(0, 99) < 4);
      case ($urandom_range(0, 3))
        0:       redirect_pc = 32'($urandom_range(0, 255));
        1:       redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        2:       redirect_pc = $urandom();
        default: redirect_pc = 32'h0;
      endcase
    end
    next();
    rst_n = 1'b1; start = 1'b0; stop = 1'b0; redirect_valid = 1'b0;
    next(); next();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/inst_fetch_ctrl.md
Name: inst_fetch_ctrl

Overview:
- Fetch sequencer that drives the address port of the combinational program ROM.
- Owns the PC and issues one ROM read per cycle into a small prefetch FIFO.
- Presents {pc, instr} to decode with a valid/ready handshake.
- Handles branch/jump redirects from execute (flush, re-steer) and start/stop control from the core top.

Parameters:
- RESET_PC, 32'h00000000, PC loaded on reset.
- FIFO_DEPTH, 2, prefetch entries; power of two, >= 2.
- NOP_INSTR, 32'h00000013, instruction value reported while out_valid=0.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; begin fetching from current PC.
- stop  in  1  single-cycle pulse; stop issuing new fetches.
- redirect_valid  in  1  execute requests PC change.
- redirect_pc  in  32  redirect target.
- rom_addr  out  32  address to Program_Rom.
- rom_data  in  32  combinational ROM read data.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  decode accepts head.
- out_pc  out  32  PC of head instruction.
- out_instr  out  32  head instruction; NOP_INSTR when out_valid=0.
- misalign_err  out  1  one-cycle pulse when redirect_pc[1:0]!=0.
- running  out  1  FSM in RUN.

Behaviour:
- Reset (async assert, sync release): pc=RESET_PC, FIFO empty, state=IDLE; out_valid=0, out_pc=0, out_instr=NOP_INSTR, misalign_err=0, running=0, rom_addr=RESET_PC.
- rom_addr = pc, combinational from the pc register.
- FSM IDLE: start -> RUN.
- FSM RUN: stop -> STOP.
- FSM STOP: start -> RUN; FIFO keeps draining while in STOP.
- Push: in RUN, if the FIFO is not full or a pop occurs the same cycle, write {pc, rom_data} and set pc += 4 (wraps mod 2^32).
  - Latency: instruction at PC visible on out_* the cycle after its push.
  - Throughput is 1 instr/cycle.
- Pop: out_valid && out_ready. Head advances. Push and pop in the same cycle on a full FIFO is legal; count is unchanged.
- Redirect: priority over push and pop in the same cycle.
  - FIFO cleared; no push that cycle; the pop is ignored (flushed head is not counted as consumed).
  - pc = {redirect_pc[31:2], 2'b00}.
  - Next cycle out_valid=0; fetch resumes from the new pc if in RUN.
- Misaligned redirect: misalign_err=1 for exactly one cycle, registered with the redirect; target is still the aligned-down address.
- Redirect in IDLE/STOP updates pc and flushes; no fetch until start.
- start and stop in the same cycle: stop wins.
- FIFO counter width is clog2(FIFO_DEPTH)+1.
  - Full: count==FIFO_DEPTH.
  - Empty: count==0.
  - Read/write pointers wrap modulo FIFO_DEPTH.
- out_* hold stable while out_valid && !out_ready, unless a redirect occurs.
- Reset mid-operation discards all FIFO content immediately.

Decomposition:
- Package fetch_pkg:
  - typedef fetch_state_e {IDLE, RUN, STOP}.
  - typedef fetch_entry_t struct {logic [31:0] pc; logic [31:0] instr;}.
  - localparam NOP_INSTR = 32'h00000013; PC_STEP = 4.
- One sub-module: fetch_fifo, parameterised by depth and entry type.
  - Inputs: push, pop, flush.
  - Outputs: full, empty, head.
- The top holds the FSM, pc, redirect logic and the ROM interface.

Test Plan:
- Reset then start, out_ready=1 -> out_pc 0x00,0x04,0x08 on consecutive cycles; out_instr 0x00500113, 0x0FBD01B7, 0x06318193; first valid one cycle after start.
- Backpressure: out_ready=0 for 5 cycles after start -> FIFO holds 0x00 and 0x04, pc stalls at 0x08; release out_ready -> 0x00, 0x04, 0x08 in order with no gap.
- Redirect to 0x34 while FIFO full -> next valid out_pc=0x34, out_instr=0x00010183; flushed entries never appear; simultaneous pop has no effect.
- Redirect to 0x36 -> misalign_err pulses one cycle; next out_pc=0x34.
- Wrap and stop: pc=0xFFFFFFFC, fetch -> out_instr=0x00000013 (ROM default), next pc=0x00000000; stop pulse halts pushes, FIFO drains, running=0.
- rst_n low mid-stream with FIFO full -> out_valid=0 immediately; after release, no fetch until start; restart yields out_pc=0x00.
